// File: rtl/vend_session_arbiter_if.sv
// Bundle of acceptor handshake, owner notifications and core money path
// seen by the session arbiter.
interface vend_session_arbiter_if;
  logic [1:0] coin_valid;
  logic [3:0] coin;
  logic [1:0] coin_ready;
  logic [1:0] grant;
  logic [1:0] vend;
  logic [1:0] change_o;
  logic [1:0] refund;
  logic [1:0] refund_amt;
  logic       err;
  logic [1:0] core_money;
  logic       core_out;
  logic [1:0] core_change;
  logic       core_rst_n;

  modport master (
    output coin_valid, coin, core_out, core_change,
    input  coin_ready, grant, vend, change_o, refund, refund_amt, err, core_money, core_rst_n
  );

  modport slave (
    input  coin_valid, coin, core_out, core_change,
    output coin_ready, grant, vend, change_o, refund, refund_amt, err, core_money, core_rst_n
  );
endinterface

// File: rtl/vend_session_arbiter.sv
// Shares one price-15 vending core between acceptors A and B: grants a session,
// forwards the owner's coins, and routes dispense, refund and core faults back.
module vend_session_arbiter #(
  parameter int IDLE_TIMEOUT = 16,
  parameter int CORE_LAT     = 1
) (
  input logic                   clk,
  input logic                   reset,
  vend_session_arbiter_if.slave bus
);
  // state      | meaning
  // S_IDLE     | no owner; arbitrate among valid requesters
  // S_SESSION  | owner feeding coins; idle timer running
  // S_DISPENSE | waiting for core_out inside the response window
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_SESSION  = 2'd1;
  localparam logic [1:0] S_DISPENSE = 2'd2;
  localparam int         TW         = $clog2(IDLE_TIMEOUT) + 1;
  localparam int         WW         = $clog2(CORE_LAT + 1) + 1;
  localparam logic [4:0] PRICE      = 5'd15;

  logic [1:0]    state;
  logic          owner, rr, hold, win_arm;
  logic [4:0]    credit;
  logic [TW-1:0] idle_cnt;
  logic [WW-1:0] win_cnt;
  logic [1:0]    money_q, vend_q, change_q, refund_q, amt_q;
  logic          err_q, core_rst_q;

  logic [1:0] ready, code;
  logic       sel, idx, xfer, good;
  logic [4:0] value, credit_sum;

  always_comb begin
    ready = 2'b00;
    sel   = (bus.coin_valid == 2'b11) ? rr : bus.coin_valid[1];
    if (state == S_IDLE && !hold && bus.coin_valid != 2'b00)
      ready[sel] = 1'b1;
    else if (state == S_SESSION)
      ready[owner] = 1'b1;
  end

  assign idx        = ready[1];
  assign xfer       = |(bus.coin_valid & ready);
  assign code       = idx ? bus.coin[3:2] : bus.coin[1:0];
  assign good       = (code == 2'b01) || (code == 2'b10);
  assign value      = (code == 2'b01) ? 5'd5 : (code == 2'b10) ? 5'd10 : 5'd0;
  assign credit_sum = credit + value;

  // Ready is combinational, so it is forced low while reset is held.
  assign bus.coin_ready = reset ? ready : 2'b00;
  assign bus.grant      = (state == S_IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);
  assign bus.core_money = money_q;
  assign bus.vend       = vend_q;
  assign bus.change_o   = change_q;
  assign bus.refund     = refund_q;
  assign bus.refund_amt = amt_q;
  assign bus.err        = err_q;
  assign bus.core_rst_n = core_rst_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      rr         <= 1'b0;
      hold       <= 1'b0;
      win_arm    <= 1'b0;
      credit     <= 5'd0;
      idle_cnt   <= '0;
      win_cnt    <= '0;
      money_q    <= 2'b00;
      vend_q     <= 2'b00;
      change_q   <= 2'b00;
      refund_q   <= 2'b00;
      amt_q      <= 2'b00;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      money_q    <= 2'b00;
      vend_q     <= 2'b00;
      change_q   <= 2'b00;
      refund_q   <= 2'b00;
      amt_q      <= 2'b00;
      err_q      <= 1'b0;
      core_rst_q <= 1'b1;
      hold       <= 1'b0;
      case (state)
        S_IDLE: begin
          if (xfer && good) begin
            owner    <= idx;
            credit   <= value;
            money_q  <= code;
            idle_cnt <= TW'(IDLE_TIMEOUT - 1);
            state    <= S_SESSION;
          end
        end
        S_SESSION: begin
          if (xfer && good) begin
            credit   <= credit_sum;
            money_q  <= code;
            idle_cnt <= TW'(IDLE_TIMEOUT - 1);
            if (credit_sum >= PRICE) begin
              state   <= S_DISPENSE;
              win_cnt <= WW'(CORE_LAT);
              win_arm <= 1'b0;
            end
          end else if (idle_cnt == '0) begin
            refund_q[owner] <= 1'b1;
            amt_q           <= (credit == 5'd10) ? 2'b10 : 2'b01;
            core_rst_q      <= 1'b0;
            credit          <= 5'd0;
            rr              <= ~owner;
            hold            <= 1'b1;
            state           <= S_IDLE;
          end else begin
            idle_cnt <= idle_cnt - TW'(1);
          end
        end
        S_DISPENSE: begin
          // First DISPENSE cycle carries the last coin to the core; sampling starts after it.
          if (!win_arm) begin
            win_arm <= 1'b1;
          end else if (bus.core_out) begin
            vend_q[owner] <= 1'b1;
            change_q      <= bus.core_change;
            err_q         <= bus.core_change != ((credit == 5'd20) ? 2'b01 : 2'b00);
            credit        <= 5'd0;
            rr            <= ~owner;
            hold          <= 1'b1;
            state         <= S_IDLE;
          end else if (win_cnt == '0) begin
            err_q      <= 1'b1;
            core_rst_q <= 1'b0;
            credit     <= 5'd0;
            rr         <= ~owner;
            hold       <= 1'b1;
            state      <= S_IDLE;
          end else begin
            win_cnt <= win_cnt - WW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/vend_session_arbiter.md
# vend_session_arbiter

Session arbiter sharing one vending core (price 15, coins 5/10, money code 01=5, 10=10) between two coin acceptors, A (index 0, front panel) and B (index 1, remote). It grants the core to one requester per transaction, forwards that requester's coins one per cycle and tracks credit independently. It routes the core's dispense and change back to the owner, and refunds or recovers on idle timeout or a missing core response. It sits between the two acceptors and the core's money input.

## Interface

- IDLE_TIMEOUT, 16: cycles with no accepted coin in SESSION before refund (≥2)
- CORE_LAT, 1: cycles after a core_money cycle until core_out is valid (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- coin_valid  in  2  per-requester coin offered
- coin  in  4  {B[3:2], A[1:0]} coin code
- coin_ready  out  2  per-requester accept; transfer = valid & ready at the edge
- grant  out  2  one-hot session owner; 00 when idle
- vend  out  2  1-cycle dispense pulse to owner
- change_o  out  2  core change, valid with vend
- refund  out  2  1-cycle refund pulse to owner
- refund_amt  out  2  01=5, 10=10, valid with refund
- err  out  1  1-cycle pulse on core fault
- core_money  out  2  to core; registered, 00 when no coin
- core_out  in  1  core dispense
- core_change  in  2  core change (01 = one 5 coin)
- core_rst_n  out  1  active-low core reset; 1-cycle pulse

## Operation

- Reset values: state IDLE, credit 0, rr pointer on A, coin_ready=00, grant=00, vend=00, change_o=00, refund=00, refund_amt=00, err=0, core_money=00, core_rst_n=1.
- States: IDLE, SESSION, DISPENSE.
- IDLE: coin_ready goes to the single winner among valid requesters. Ties go to the rr pointer. On a transfer, latch owner, set grant, add the coin to credit, go to SESSION.
- SESSION: coin_ready = owner only; the other requester is stalled (ready=0).
  - Each transfer: core_money = coin for exactly the next cycle, and credit += value.
  - Credit ≥15 → DISPENSE. coin_ready drops in the same cycle the state changes.
- Coin codes 00/11 with valid are accepted and discarded: no forward, no credit change, idle counter not reset.
- DISPENSE: sample core_out for up to CORE_LAT+1 cycles after the core_money cycle.
  - First core_out=1: next cycle vend[owner]=1 and change_o=core_change; then IDLE with grant=00, credit=0, rr pointer to the non-owner.
  - core_change ≠ expected (01 if credit 20, 00 if 15): vend still issued, plus err=1 in the same cycle.
  - No core_out in the window: err=1, core_rst_n=0 for one cycle, no vend, no refund; IDLE and rr flip.
- Idle timeout: in SESSION, counter reset on each valid transfer. On reaching IDLE_TIMEOUT:
  - refund[owner]=1, refund_amt=credit/5 (01 or 10), core_rst_n=0, both for one cycle.
  - Then IDLE, credit 0, rr flip.
- Credit width 5 bits; maximum credit is 20.
- Mid-operation reset: all outputs return to reset values immediately. No vend or refund is issued for credit in flight.

## Timing

- Transfer at edge T → core_money valid in T+1 → core_out expected in cycle T+1+CORE_LAT.
- vend/change_o asserted in the cycle after core_out is seen; grant deasserts in that same vend cycle.
- A new session may be granted (coin_ready high) in the cycle after the vend/refund/err cycle.
- Back-to-back coins from the owner are accepted every cycle in SESSION.
- Simultaneous timeout and transfer in one cycle: the transfer wins and the counter clears.

## Test plan

- A offers 01,01,01 on consecutive cycles → core_money 01 ×3, DISPENSE; with core_out=1 → vend=01, change_o=00, grant=00, rr points to B.
- B offers 10,10 → vend=10, change_o=01; core_change=00 instead → vend=10 plus err=1.
- A and B both valid in IDLE, pointer on A → A granted and B ready=0 for the whole session; B granted on the first cycle it is eligible after A's vend.
- A offers 10, then no coins for 16 cycles → refund=01, refund_amt=10, core_rst_n low one cycle, back to IDLE.
- A reaches 15, core_out held 0 → err=1 at window end, core_rst_n pulse, no vend.
- reset low while A holds credit 10 in SESSION → all outputs zero immediately; after release, B is granted normally.
